// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared FSM state encoding and address-decode field
// positions for the mem_io_bridge memory/IO steering block.
package mem_io_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MEM_RD = 3'd1,
    S_IO_RD  = 3'd2,
    S_IO_WR  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // addr[31:10] selects the IO window
  localparam int WIN_LSB = 10;
  localparam int WIN_W   = 32 - WIN_LSB;

  // addr[7:4] selects the IO channel
  localparam int CH_LSB  = 4;
  localparam int CH_W    = 4;

endpackage

// File: rtl/mem_io_decode.sv
// mem_io_decode: combinational address decode for the IO window.
// Ports: win_i (addr[31:10]), chf_i (addr[7:4]) in;
//        ch_o (channel), mapped_o (window hit, ch<N_IO), cs_o (one-hot) out.
module mem_io_decode
  import mem_io_pkg::*;
#(
  parameter int               N_IO    = 4,
  parameter logic [WIN_W-1:0] IO_BASE = 22'h3FFFFF
) (
  input  logic [WIN_W-1:0] win_i,
  input  logic [CH_W-1:0]  chf_i,
  output logic [CH_W-1:0]  ch_o,
  output logic             mapped_o,
  output logic [N_IO-1:0]  cs_o
);

  logic is_io;

  always_comb begin
    is_io    = (win_i == IO_BASE);
    ch_o     = chf_i;
    mapped_o = is_io && ({1'b0, chf_i} < 5'(N_IO));
    for (int k = 0; k < N_IO; k++) begin
      cs_o[k] = mapped_o && (chf_i == CH_W'(k));
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: steers CPU loads/stores to Data-Memory or one-hot IO
// channels, stalling the CPU until multi-cycle reads / IO handshakes end.
// Ports: clock, reset (async high), mRead/mWrite/ioRead/ioWrite requests,
//   addr_in, r_rdata, m_rdata, io_rdata, io_ready in; addr_out, write_data,
//   m_we, io_cs, io_rd, io_wr, r_wdata, stall out.
// Option MEM_IO_BUSERR_EN adds bus_err pulse and saturating err_cnt[7:0].
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int               N_IO       = 4,
  parameter int               IO_W       = 16,
  parameter logic [WIN_W-1:0] IO_BASE    = 22'h3FFFFF,
  parameter int               MEM_RD_LAT = 1,
  parameter int               IO_TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mRead,
  input  logic                   mWrite,
  input  logic                   ioRead,
  input  logic                   ioWrite,
  input  logic [31:0]            addr_in,
  input  logic [31:0]            r_rdata,
  input  logic [31:0]            m_rdata,
  input  logic [N_IO*IO_W-1:0]   io_rdata,
  input  logic [N_IO-1:0]        io_ready,
  output logic [31:0]            addr_out,
  output logic [31:0]            write_data,
  output logic                   m_we,
  output logic [N_IO-1:0]        io_cs,
  output logic                   io_rd,
  output logic                   io_wr,
  output logic [31:0]            r_wdata,
  output logic                   stall
`ifdef MEM_IO_BUSERR_EN
  ,
  output logic                   bus_err,
  output logic [7:0]             err_cnt
`endif
);

  localparam int CW = $clog2(IO_TIMEOUT + MEM_RD_LAT + 2);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [N_IO-1:0]   cs_q, cs_d;
  logic              map_q, map_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [CH_W-1:0]   dec_ch;
  logic              dec_map;
  logic [N_IO-1:0]   dec_cs;
  logic [IO_W-1:0]   io_sel;
  logic [31:0]       io_ext;
  logic              hit;

  mem_io_decode #(
    .N_IO    (N_IO),
    .IO_BASE (IO_BASE)
  ) u_dec (
    .win_i    (addr_in[31:WIN_LSB]),
    .chf_i    (addr_in[CH_LSB +: CH_W]),
    .ch_o     (dec_ch),
    .mapped_o (dec_map),
    .cs_o     (dec_cs)
  );

  // read data of the latched channel, zero-extended
  always_comb begin
    io_sel = '0;
    for (int k = 0; k < N_IO; k++) begin
      if (ch_q == CH_W'(k)) io_sel = io_rdata[k*IO_W +: IO_W];
    end
    io_ext = '0;
    io_ext[IO_W-1:0] = io_sel;
    hit = map_q && |(io_ready & cs_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      cs_q    <= '0;
      map_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      cs_q    <= cs_d;
      map_q   <= map_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    cs_d    = cs_q;
    map_d   = map_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (mRead) begin
          state_d = S_MEM_RD;
        end else if (!mWrite && (ioRead || ioWrite)) begin
          state_d = ioRead ? S_IO_RD : S_IO_WR;
          ch_d    = dec_ch;
          cs_d    = dec_cs;
          map_d   = dec_map;
          wdata_d = r_rdata;
        end
      end
      S_MEM_RD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(MEM_RD_LAT - 1)) begin
          rdata_d = m_rdata;
          state_d = S_DONE;
        end
      end
      S_IO_RD, S_IO_WR: begin
        cnt_d = cnt_q + CW'(1);
        // unmapped channels give up on their first cycle
        if (hit) begin
          state_d = S_DONE;
          if (state_q == S_IO_RD) rdata_d = io_ext;
        end else if (!map_q ||
                     cnt_q == CW'(IO_TIMEOUT - 1)) begin
          state_d = S_DONE;
          if (state_q == S_IO_RD) rdata_d = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // gated by reset so IDLE's combinational
  // strobes cannot leak while reset is held
  always_comb begin
    stall      = 1'b0;
    m_we       = 1'b0;
    write_data = '0;
    io_cs      = '0;
    io_rd      = 1'b0;
    io_wr      = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_IDLE: begin
          stall = mRead ||
                  (!mWrite && (ioRead || ioWrite));
          if (!mRead && mWrite) begin
            m_we       = 1'b1;
            write_data = r_rdata;
          end
        end
        S_MEM_RD: stall = 1'b1;
        S_IO_RD: begin
          stall = 1'b1;
          io_cs = cs_q;
          io_rd = map_q;
        end
        S_IO_WR: begin
          stall      = 1'b1;
          io_cs      = cs_q;
          io_wr      = map_q;
          write_data = map_q ? wdata_q : '0;
        end
        default: ;
      endcase
    end
  end

  assign addr_out = addr_in;
  assign r_wdata  = rdata_q;

`ifdef MEM_IO_BUSERR_EN
  logic       err_q;
  logic [7:0] err_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (state_d == S_DONE)
        err_q <= (state_q == S_IO_RD ||
                  state_q == S_IO_WR) && !hit;
      if (state_q == S_DONE && err_q &&
          err_cnt_q != 8'hFF)
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus_err = (state_q == S_DONE) && err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule
